// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and bus widths.
package axi_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic                    awvalid;
    logic                    awready;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [2:0]              awprot;

    logic                    wvalid;
    logic                    wready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;

    logic                    bvalid;
    logic                    bready;
    resp_t                   bresp;

    logic                    arvalid;
    logic                    arready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [2:0]              arprot;

    logic                    rvalid;
    logic                    rready;
    logic [AXI_DATA_W-1:0]   rdata;
    resp_t                   rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: register 0 is a read-only ID, the rest are
// byte-writable. Write address and data are joined through holding
// registers; reads complete with one cycle of latency.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned N_REGS    = 8,
    parameter logic [31:0] ID_VALUE  = 32'hA11E_0001,
    parameter logic [31:0] RST_VALUE = 32'h0
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    axi_lite_if.slave                         s_if,
    output logic [N_REGS-1:0][AXI_DATA_W-1:0] reg_q,
    output logic [N_REGS-1:0]                 wr_pulse
);

    localparam int IDX_W  = $clog2(N_REGS);
    localparam int STRB_W = AXI_DATA_W / 8;

    // Decode an address into its response; only writes see register 0 as read-only.
    function automatic resp_t decode_resp(input logic [AXI_ADDR_W-1:0] addr,
                                          input logic is_write);
        if (addr[AXI_ADDR_W-1:2+IDX_W] != '0) return DECERR;
        if (addr[1:0] != 2'b00) return SLVERR;
        if (is_write && (addr[2 +: IDX_W] == '0)) return SLVERR;
        return OKAY;
    endfunction

    // Byte-lane merge of new data into an old word.
    function automatic logic [AXI_DATA_W-1:0] merge_bytes(input logic [AXI_DATA_W-1:0] old_w,
                                                          input logic [AXI_DATA_W-1:0] new_w,
                                                          input logic [STRB_W-1:0]     strb);
        logic [AXI_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Write-side state
    logic                              aw_held_q, aw_held_d;
    logic [AXI_ADDR_W-1:0]             awaddr_q, awaddr_d;
    logic                              w_held_q, w_held_d;
    logic [AXI_DATA_W-1:0]             wdata_q, wdata_d;
    logic [STRB_W-1:0]                 wstrb_q, wstrb_d;
    logic                              bvalid_q, bvalid_d;
    resp_t                             bresp_q, bresp_d;
    logic [N_REGS-1:0][AXI_DATA_W-1:0] reg_d;
    logic [N_REGS-1:0]                 wr_pulse_q, wr_pulse_d;

    // Read-side state
    logic                              rvalid_q, rvalid_d;
    logic [AXI_DATA_W-1:0]             rdata_q, rdata_d;
    resp_t                             rresp_q, rresp_d;

    // Handshake and join signals
    logic                              aw_hs, w_hs, ar_hs;
    logic                              commit;
    logic [AXI_ADDR_W-1:0]             wr_addr;
    logic [AXI_DATA_W-1:0]             wr_data;
    logic [STRB_W-1:0]                 wr_strb;
    logic [IDX_W-1:0]                  wr_idx;
    resp_t                             wr_resp;
    logic [IDX_W-1:0]                  rd_idx;
    resp_t                             rd_resp;

    // Protection bits carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{s_if.awprot, s_if.arprot};

    // Ready terms are gated by the reset pin so they read low while held in reset.
    assign s_if.awready = aresetn && !aw_held_q && !bvalid_q;
    assign s_if.wready  = aresetn && !w_held_q  && !bvalid_q;
    assign s_if.arready = aresetn && !rvalid_q;
    assign s_if.bvalid  = bvalid_q;
    assign s_if.bresp   = bresp_q;
    assign s_if.rvalid  = rvalid_q;
    assign s_if.rdata   = rdata_q;
    assign s_if.rresp   = rresp_q;
    assign wr_pulse     = wr_pulse_q;

    assign aw_hs = s_if.awvalid && s_if.awready;
    assign w_hs  = s_if.wvalid  && s_if.wready;
    assign ar_hs = s_if.arvalid && s_if.arready;

    // A channel counts as present if it is held or handshaking this cycle.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : s_if.awaddr;
    assign wr_data = w_held_q  ? wdata_q  : s_if.wdata;
    assign wr_strb = w_held_q  ? wstrb_q  : s_if.wstrb;
    assign wr_idx  = wr_addr[2 +: IDX_W];
    assign wr_resp = decode_resp(wr_addr, 1'b1);
    assign rd_idx  = s_if.araddr[2 +: IDX_W];
    assign rd_resp = decode_resp(s_if.araddr, 1'b0);

    // Write join: capture AW/W independently, commit once both are present.
    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        reg_d      = reg_q;
        wr_pulse_d = '0;

        if (bvalid_q && s_if.bready) bvalid_d = 1'b0;

        if (commit) begin
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            if ((wr_resp == OKAY) && (wr_strb != '0)) begin
                reg_d[wr_idx]      = merge_bytes(reg_q[wr_idx], wr_data, wr_strb);
                wr_pulse_d[wr_idx] = 1'b1;
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_if.awaddr;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_if.wdata;
                wstrb_d  = s_if.wstrb;
            end
        end
    end

    // Read path: sample the current (pre-write) register contents on AR handshake.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && s_if.rready) rvalid_d = 1'b0;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_resp;
            if (rd_resp != OKAY)   rdata_d = '0;
            else if (rd_idx == '0) rdata_d = ID_VALUE;
            else                   rdata_d = reg_q[rd_idx];
        end
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            for (int i = 0; i < int'(N_REGS); i++) begin
                reg_q[i] <= (i == 0) ? ID_VALUE : RST_VALUE;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            reg_q      <= reg_d;
        end
    end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter N_REGS, default 8, number of 32-bit registers; legal range 2..256, power of two.
REQ-002 SHALL have parameter ID_VALUE, default 32'hA11E_0001, constant value of read-only register 0.
REQ-003 SHALL have parameter RST_VALUE, default 32'h0, reset value of registers 1..N_REGS-1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 aclk  input  1  sole clock; all state changes on rising edge.
REQ-006 aresetn  input  1  asynchronous active-low reset.
REQ-007 s_if  axi_lite_if slave side  -  AXI4-Lite responder:
- Inputs: aw*/w*/ar* valid, addr, data, strb and prot, plus bready and rready.
- Outputs: awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp.
REQ-008 reg_q  output  N_REGS x 32  current register contents to hardware.
REQ-009 wr_pulse  output  N_REGS  one-cycle strobe per register on a committed, successful write.

Function
REQ-010 Address decode:
- idx = addr[2 +: log2(N_REGS)].
- Out of range when addr[31:2+log2(N_REGS)] != 0.
- Unaligned when addr[1:0] != 0.
- awprot and arprot are ignored.
REQ-011 Write address and write data SHALL be accepted independently, in either order or in the same cycle. Each channel is captured into a holding register when not already held.
REQ-012 awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-013 Write commit:
- Occurs on the edge where both address and data are present, each either held or handshaking that cycle.
- bvalid rises at that edge; both held flags clear.
- Latency: bvalid is visible the cycle after the later of the two handshakes.
REQ-014 On commit, bytes with wstrb[b]=1 SHALL update, other bytes unchanged; wstrb=4'h0 is OKAY with no change and no wr_pulse.
REQ-015 bresp priority:
- DECERR (2'b11) if out of range.
- Else SLVERR (2'b10) if unaligned, or if idx=0 (read-only).
- Else OKAY (2'b00).
- Any error: no register change, no wr_pulse.
REQ-016 bvalid and bresp SHALL stay stable until bvalid && bready; bvalid falls on that edge. No new AW or W is accepted while bvalid=1.
REQ-017 arready = !rvalid. On an AR handshake, rdata and rresp register at that edge and rvalid rises, giving one-cycle latency.
REQ-018 Read data:
- idx=0 returns ID_VALUE.
- Other in-range reads return reg_q[idx].
- Error reads return rdata=0 with rresp per REQ-015's DECERR/SLVERR rules; the read-only rule does not apply to reads.
REQ-019 rvalid, rdata and rresp SHALL stay stable until rvalid && rready.
REQ-020 A read and a write to the same register on the same edge SHALL return the pre-write value.
REQ-021 Read and write channels SHALL operate concurrently with no mutual stalling.
REQ-022 wr_pulse[idx] SHALL be high exactly for the cycle after the commit edge.

Reset
REQ-023 While aresetn=0:
- bvalid, rvalid and wr_pulse = 0; rdata = 0; bresp and rresp = 2'b00.
- awready, wready and arready = 0; holding flags cleared.
- reg_q[0] = ID_VALUE; others = RST_VALUE.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no partial register update.
REQ-025 The first cycle after deassertion SHALL have awready, wready and arready = 1.

Structure
REQ-026 Shared package axi_lite_pkg SHALL hold the resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the AXI_DATA_W=32 / AXI_ADDR_W=32 constants.
REQ-027 Single module with no sub-module; the write join and read path are small enough to stay inline.

Verification
REQ-028 AW 0x0000_0004 and W 0xDEADBEEF with strb F in the same cycle, bready=1:
- bvalid rises the next cycle with bresp=00.
- reg_q[1]=0xDEADBEEF; wr_pulse[1] pulses once.
REQ-029 W 0x11223344 with strb 4'b0101 three cycles before AW 0x8, previous reg_q[2]=0xAABBCCDD:
- wready=0 while W is held.
- Result reg_q[2]=0xAA22CC44, bresp=00.
REQ-030 Error writes:
- Write to 0x0 -> SLVERR, reg_q[0]=ID_VALUE.
- Write to 0x100 (N_REGS=8) -> DECERR.
- Write to 0x6 -> SLVERR.
- No wr_pulse for any of them.
REQ-031 Reads:
- AR 0x4 with rready held low for 5 cycles: rvalid high and rdata=0xDEADBEEF stable throughout; arready=0 until the R handshake.
- AR 0x0 returns ID_VALUE.
- AR 0x100 returns DECERR with rdata=0.
REQ-032 Same-edge read of 0xC and write of 0x5A5A5A5A to 0xC: rdata returns the old value; a subsequent read returns 0x5A5A5A5A.
REQ-033 aresetn pulsed low after an AW handshake but before W: all outputs take reset values, and a later lone W does not commit until a new AW arrives.
